// File: rtl/tune_sequencer_if.sv
// Control and tone-output bundle between a tune sequencer and its controller.
interface tune_sequencer_if;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [15:0] tempo;
    logic [11:0] divider;
    logic        gate;
    logic        busy;
    logic [3:0]  note_idx;
    logic        done;

    modport master (
        output start, stop, loop_en, tempo,
        input  divider, gate, busy, note_idx, done
    );

    modport slave (
        input  start, stop, loop_en, tempo,
        output divider, gate, busy, note_idx, done
    );
endinterface

// File: rtl/tune_sequencer.sv
// Tune sequencer: plays a fixed 16-entry note ROM as tone divider + gate.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; gate low, busy low
// LOAD  | one cycle: fetch ROM entry at note_idx, end-marker / loop decision
// PLAY  | sounding (or resting) the loaded entry for dur ticks
module tune_sequencer (
    input  logic            clk,
    input  logic            rst,
    tune_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  note_idx_q;
    logic [11:0] divider_q;
    logic        done_q;
    logic [3:0]  remaining_q;
    logic [15:0] tick_cnt_q;
    logic [15:0] tempo_q;
    logic        rest_q;
    logic [3:0]  dur_q;

    logic [16:0] rom_entry;
    logic        rom_rest;
    logic [3:0]  rom_dur;
    logic [11:0] rom_div;
    logic        tick;
    logic        last_tick;
    logic        loop_restart;

    // Note ROM, entry = {rest, dur, div}; dur == 0 marks end of tune.
    always_comb begin
        rom_entry = 17'd0;
        case (note_idx_q)
            4'd0:    rom_entry = {1'b0, 4'd2, 12'd745};
            4'd1:    rom_entry = {1'b0, 4'd2, 12'd664};
            4'd2:    rom_entry = {1'b0, 4'd2, 12'd591};
            4'd3:    rom_entry = {1'b1, 4'd1, 12'd0};
            4'd4:    rom_entry = {1'b0, 4'd3, 12'd497};
            4'd5:    rom_entry = {1'b0, 4'd1, 12'd591};
            4'd6:    rom_entry = {1'b0, 4'd4, 12'd745};
            default: rom_entry = 17'd0;
        endcase
    end

    assign rom_rest     = rom_entry[16];
    assign rom_dur      = rom_entry[15:12];
    assign rom_div      = rom_entry[11:0];
    assign tick         = (state == PLAY) && (tick_cnt_q == tempo_q);
    assign last_tick    = tick && (remaining_q == 4'd1);
    assign loop_restart = bus.loop_en && (note_idx_q != 4'd0);

    // Next-state decode; stop overrides everything, start only counts in IDLE.
    always_comb begin
        state_nxt = state;
        if (bus.stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.start) state_nxt = LOAD;
                LOAD: begin
                    if (rom_dur != 4'd0)  state_nxt = PLAY;
                    else if (loop_restart) state_nxt = LOAD;
                    else                   state_nxt = IDLE;
                end
                PLAY: if (last_tick) state_nxt = LOAD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath: note index, tone divider, tick timing and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            note_idx_q  <= 4'd0;
            divider_q   <= 12'd0;
            done_q      <= 1'b0;
            remaining_q <= 4'd0;
            tick_cnt_q  <= 16'd0;
            tempo_q     <= 16'd0;
            rest_q      <= 1'b0;
            dur_q       <= 4'd0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                note_idx_q <= 4'd0;
                tick_cnt_q <= 16'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            tempo_q    <= bus.tempo;
                            note_idx_q <= 4'd0;
                        end
                    end
                    LOAD: begin
                        if (rom_dur != 4'd0) begin
                            // A rest keeps the previous pitch so the tone generator never glitches.
                            if (!rom_rest) divider_q <= rom_div;
                            remaining_q <= rom_dur;
                            tick_cnt_q  <= 16'd0;
                            rest_q      <= rom_rest;
                            dur_q       <= rom_dur;
                        end else if (loop_restart) begin
                            note_idx_q <= 4'd0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (tick) begin
                            tick_cnt_q <= 16'd0;
                            if (remaining_q == 4'd1) note_idx_q  <= note_idx_q + 4'd1;
                            else                     remaining_q <= remaining_q - 4'd1;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Gate drops on the last tick of multi-tick notes to separate repeated pitches.
    assign bus.gate     = (state == PLAY) && !rest_q &&
                          !((remaining_q == 4'd1) && (dur_q >= 4'd2));
    assign bus.busy     = (state != IDLE);
    assign bus.divider  = divider_q;
    assign bus.note_idx = note_idx_q;
    assign bus.done     = done_q;

endmodule
